// File: rtl/aes_pkg.sv
// Shared AES tables and helpers for the iterative inverse cipher: S-boxes, Rcon,
// GF(2^8) multiplies for InvMixColumns, and the controller state encoding.
package aes_pkg;

  localparam int NB = 4;

  // Expanded key length in 32-bit words for a given round count.
  function automatic int kw_words(input int nr);
    return NB * (nr + 1);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEXP  = 3'd1,
    ST_INIT  = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } aes_state_e;

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] x9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] xb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] xd(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] xe(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xe(a0) ^ xb(a1) ^ xd(a2) ^ x9(a3),
            x9(a0) ^ xe(a1) ^ xb(a2) ^ xd(a3),
            xd(a0) ^ x9(a1) ^ xe(a2) ^ xb(a3),
            xb(a0) ^ xd(a1) ^ x9(a2) ^ xe(a3)};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless last_round_i is set.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rkey_i,
  input  logic         last_round_i,
  output logic [127:0] state_o
);

  logic [127:0] sub_q_unused_free;
  logic [127:0] ark;
  logic [127:0] mix;

  always_comb begin
    sub_q_unused_free = '0;
    // Byte 4c+r is row r of column c; row r rotates right by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_q_unused_free[8*(15-(4*c+r)) +: 8] =
          inv_sbox(state_i[8*(15-(4*((c+4-r)%4)+r)) +: 8]);
      end
    end
    ark = sub_q_unused_free ^ rkey_i;
    mix = '0;
    for (int c = 0; c < 4; c++) begin
      mix[32*(3-c) +: 32] = inv_mix_col(ark[32*(3-c) +: 32]);
    end
    state_o = last_round_i ? ark : mix;
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128/192/256 inverse cipher: one key word per cycle, then one round
// per cycle. Optional last-key reuse under macro AES_KEY_CACHE_EN.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*Nk-1:0]  key_in,
  input  logic [127:0]      data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      data_out,
  output logic              busy,
  output aes_state_e        state_dbg_o
);

  localparam int KW = kw_words(Nr);

  if (!((Nk == 4 || Nk == 6 || Nk == 8) && Nr == Nk + 6)) begin : g_bad_cfg
    $error("aes_inv_cipher_iter: illegal Nk/Nr combination");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its data hold steady until that edge.
  aes_state_e     state_q;
  logic           in_ready_q, out_valid_q, busy_q;
  logic [127:0]   data_out_q, blk_q;
  logic [5:0]     i_q;
  logic [3:0]     kmod_q, rc_idx_q, r_q;
  logic [31:0]    w_q [KW];
  logic [31:0]    prev_w, temp, kexp_d;
  logic [127:0]   rkey, round_d;
  logic           accept, cache_hit;

  assign accept = in_valid && (state_q == ST_IDLE) && reset;

  always_comb begin
    prev_w = w_q[i_q - 6'd1];
    temp   = prev_w;
    if (kmod_q == 4'd0)
      temp = subword({prev_w[23:0], prev_w[31:24]}) ^ {rcon(rc_idx_q), 24'h0};
    else if (Nk == 8 && kmod_q == 4'd4)
      temp = subword(prev_w);
    kexp_d = w_q[i_q - 6'(Nk)] ^ temp;
  end

  assign rkey = {w_q[{r_q, 2'd0}], w_q[{r_q, 2'd1}], w_q[{r_q, 2'd2}], w_q[{r_q, 2'd3}]};

  aes_inv_round u_round (
    .state_i      (blk_q),
    .rkey_i       (rkey),
    .last_round_i (r_q == 4'd0),
    .state_o      (round_d)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < Nk; k++) w_q[k] <= key_in[32*(Nk-1-k) +: 32];
    end else if (state_q == ST_KEXP) begin
      w_q[i_q] <= kexp_d;
    end
  end

`ifdef AES_KEY_CACHE_EN
  logic              cache_valid_q;
  logic [32*Nk-1:0]  cached_key;

  always_comb begin
    cached_key = '0;
    for (int k = 0; k < Nk; k++) cached_key[32*(Nk-1-k) +: 32] = w_q[k];
  end

  assign cache_hit = cache_valid_q && (key_in == cached_key);

  // A miss overwrites w[0..Nk-1], so the schedule is stale until KEXP completes.
  always_ff @(posedge clk) begin
    if (!reset)                                     cache_valid_q <= 1'b0;
    else if (accept && !cache_hit)                  cache_valid_q <= 1'b0;
    else if (state_q == ST_KEXP && i_q == 6'(KW-1)) cache_valid_q <= 1'b1;
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      data_out_q  <= '0;
      blk_q       <= '0;
      i_q         <= '0;
      kmod_q      <= '0;
      rc_idx_q    <= '0;
      r_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          blk_q      <= data_in;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          if (cache_hit) begin
            state_q <= ST_INIT;
            r_q     <= 4'(Nr);
          end else begin
            state_q  <= ST_KEXP;
            i_q      <= 6'(Nk);
            kmod_q   <= 4'd0;
            rc_idx_q <= 4'd1;
          end
        end
        ST_KEXP: begin
          i_q    <= i_q + 6'd1;
          kmod_q <= (kmod_q == 4'(Nk-1)) ? 4'd0 : kmod_q + 4'd1;
          if (kmod_q == 4'd0) rc_idx_q <= rc_idx_q + 4'd1;
          if (i_q == 6'(KW-1)) begin
            state_q <= ST_INIT;
            r_q     <= 4'(Nr);
          end
        end
        ST_INIT: begin
          blk_q   <= blk_q ^ rkey;
          r_q     <= r_q - 4'd1;
          state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          blk_q <= round_d;
          if (r_q == 4'd0) begin
            data_out_q  <= round_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            r_q <= r_q - 4'd1;
          end
        end
        ST_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign data_out    = data_out_q;
  assign busy        = busy_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed-vector bench for aes_inv_cipher_iter at AES-128/192/256, including
// back-pressure, mid-operation reset and (with AES_KEY_CACHE_EN) key reuse.
module tb_aes_inv_cipher_iter;
  import aes_pkg::*;

  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KB    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CTB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PTB   = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_KEY_CACHE_EN
  localparam int HIT_LAT = 11;
`else
  localparam int HIT_LAT = 51;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [2:0] iv, ordy;
  logic [255:0] key_v [3];
  logic [127:0] din_v [3];
  logic rdy0, rdy1, rdy2, ov0, ov1, ov2, busy0, busy1, busy2;
  logic [127:0] dout0, dout1, dout2;
  aes_state_e st0, st1, st2;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_inv_cipher_iter #(.Nk(4), .Nr(10)) dut (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy0),
    .key_in(key_v[0][255:128]), .data_in(din_v[0]), .out_valid(ov0),
    .out_ready(ordy[0]), .data_out(dout0), .busy(busy0), .state_dbg_o(st0));

  aes_inv_cipher_iter #(.Nk(6), .Nr(12)) dut6 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy1),
    .key_in(key_v[1][255:64]), .data_in(din_v[1]), .out_valid(ov1),
    .out_ready(ordy[1]), .data_out(dout1), .busy(busy1), .state_dbg_o(st1));

  aes_inv_cipher_iter #(.Nk(8), .Nr(14)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(rdy2),
    .key_in(key_v[2]), .data_in(din_v[2]), .out_valid(ov2),
    .out_ready(ordy[2]), .data_out(dout2), .busy(busy2), .state_dbg_o(st2));

  function automatic logic get_ov(input int s);
    return (s == 0) ? ov0 : (s == 1) ? ov1 : ov2;
  endfunction

  function automatic logic get_rdy(input int s);
    return (s == 0) ? rdy0 : (s == 1) ? rdy1 : rdy2;
  endfunction

  function automatic logic [127:0] get_dout(input int s);
    return (s == 0) ? dout0 : (s == 1) ? dout1 : dout2;
  endfunction

  // Offer one request, then count posedges from the accept edge to out_valid.
  task automatic do_req(input int s, input logic [255:0] key, input logic [127:0] ct,
                        output int lat, output logic [127:0] pt);
    @(negedge clk);
    key_v[s] = key;
    din_v[s] = ct;
    iv[s]    = 1'b1;
    @(posedge clk);
    #1 iv[s] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!get_ov(s) && lat < 300);
    pt = get_dout(s);
  endtask

  task automatic release_out(input int s);
    @(negedge clk);
    ordy[s] = 1'b1;
    @(posedge clk);
    #1 ordy[s] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    iv = '0;
    ordy = '0;
    for (int k = 0; k < 3; k++) begin
      key_v[k] = '0;
      din_v[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({rdy0, ov0, busy0} !== 3'b100) begin errors++;
      $display("FAIL reset_flags: got rdy/ov/busy=%b expected 100", {rdy0, ov0, busy0}); end
    checks++; if (dout0 !== 128'h0) begin errors++;
      $display("FAIL reset_data: got %h expected 0", dout0); end
    checks++; if (st0 !== ST_IDLE) begin errors++;
      $display("FAIL reset_state: got %0d expected %0d", st0, ST_IDLE); end
    checks++; if ({rdy1, rdy2, busy1, busy2} !== 4'b1100) begin errors++;
      $display("FAIL reset_wide: got %b expected 1100", {rdy1, rdy2, busy1, busy2}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_aes_variant(input int s, input logic [255:0] key,
                                  input logic [127:0] ct, input int exp_lat);
    int lat;
    logic [127:0] pt;
    checks++; if (get_rdy(s) !== 1'b1) begin errors++;
      $display("FAIL ready_before_nk%0d: got %b expected 1", 2*s+4, get_rdy(s)); end
    do_req(s, key, ct, lat, pt);
    checks++; if (lat !== exp_lat) begin errors++;
      $display("FAIL latency_nk%0d: got %0d expected %0d", 2*s+4, lat, exp_lat); end
    checks++; if (pt !== PT) begin errors++;
      $display("FAIL plaintext_nk%0d: got %h expected %h", 2*s+4, pt, PT); end
    release_out(s);
    checks++; if ({get_ov(s), get_rdy(s)} !== 2'b01) begin errors++;
      $display("FAIL handshake_nk%0d: got ov/rdy=%b expected 01", 2*s+4, {get_ov(s), get_rdy(s)}); end
  endtask

  task automatic test_aes128();
    int lat;
    logic [127:0] pt;
    do_req(0, K128, CT128, lat, pt);
    checks++; if (lat !== 51) begin errors++;
      $display("FAIL c1_latency: got %0d expected 51", lat); end
    checks++; if (pt !== PT) begin errors++;
      $display("FAIL c1_plaintext: got %h expected %h", pt, PT); end
    checks++; if ({rdy0, busy0, st0 == ST_DONE} !== 3'b011) begin errors++;
      $display("FAIL c1_done_flags: got rdy/busy/done=%b expected 011", {rdy0, busy0, st0 == ST_DONE}); end
    release_out(0);
    checks++; if ({ov0, rdy0, busy0} !== 3'b010) begin errors++;
      $display("FAIL c1_after_handshake: got ov/rdy/busy=%b expected 010", {ov0, rdy0, busy0}); end
  endtask

  task automatic test_back_pressure();
    int lat;
    logic [127:0] pt;
    do_req(0, KB, CTB, lat, pt);
    checks++; if (lat !== 51 || pt !== PTB) begin errors++;
      $display("FAIL bp_result: got lat=%0d pt=%h expected 51 %h", lat, pt, PTB); end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      iv[0] = n[0];
      key_v[0] = K128;
      din_v[0] = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      checks++; if ({ov0, rdy0, dout0} !== {1'b1, 1'b0, PTB}) begin errors++;
        $display("FAIL bp_hold_%0d: got ov=%b rdy=%b data=%h expected 1 0 %h", n, ov0, rdy0, dout0, PTB); end
    end
    iv[0] = 1'b0;
    release_out(0);
    checks++; if ({ov0, rdy0} !== 2'b01) begin errors++;
      $display("FAIL bp_release: got ov/rdy=%b expected 01", {ov0, rdy0}); end
    @(posedge clk);
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++;
      $display("FAIL bp_no_stray_accept: got busy=%b expected 0", busy0); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [127:0] pt;
    ordy[0] = 1'b1;
    do_req(0, K128, CT128, lat, pt);
    checks++; if (lat !== 51 || pt !== PT) begin errors++;
      $display("FAIL b2b_first: got lat=%0d pt=%h expected 51 %h", lat, pt, PT); end
    @(posedge clk);
    #1;
    checks++; if ({ov0, rdy0} !== 2'b01) begin errors++;
      $display("FAIL b2b_handshake: got ov/rdy=%b expected 01", {ov0, rdy0}); end
    do_req(0, KB, CTB, lat, pt);
    checks++; if (lat !== 51 || pt !== PTB) begin errors++;
      $display("FAIL b2b_second: got lat=%0d pt=%h expected 51 %h", lat, pt, PTB); end
    @(posedge clk);
    #1 ordy[0] = 1'b0;
    checks++; if ({ov0, rdy0} !== 2'b01) begin errors++;
      $display("FAIL b2b_end: got ov/rdy=%b expected 01", {ov0, rdy0}); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    logic [127:0] pt;
    @(negedge clk);
    key_v[0] = K128;
    din_v[0] = CT128;
    iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (44) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({rdy0, ov0, busy0} !== 3'b100 || dout0 !== 128'h0) begin errors++;
      $display("FAIL midreset_outputs: got rdy/ov/busy=%b data=%h expected 100 0", {rdy0, ov0, busy0}, dout0); end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (60) begin
      @(posedge clk);
      #1 if (ov0) seen++;
    end
    checks++; if (seen !== 0) begin errors++;
      $display("FAIL midreset_no_partial: got %0d valid cycles expected 0", seen); end
    do_req(0, KB, CTB, lat, pt);
    checks++; if (lat !== 51 || pt !== PTB) begin errors++;
      $display("FAIL midreset_bvector: got lat=%0d pt=%h expected 51 %h", lat, pt, PTB); end
    release_out(0);
  endtask

  task automatic test_key_cache();
    int lat;
    logic [127:0] pt;
    do_req(0, KB, CTB, lat, pt);
    checks++; if (lat !== HIT_LAT || pt !== PTB) begin errors++;
      $display("FAIL cache_same_key: got lat=%0d pt=%h expected %0d %h", lat, pt, HIT_LAT, PTB); end
    release_out(0);
    do_req(0, K128, CT128, lat, pt);
    checks++; if (lat !== 51 || pt !== PT) begin errors++;
      $display("FAIL cache_new_key: got lat=%0d pt=%h expected 51 %h", lat, pt, PT); end
    release_out(0);
    do_req(0, K128, CT128, lat, pt);
    checks++; if (lat !== HIT_LAT || pt !== PT) begin errors++;
      $display("FAIL cache_reuse: got lat=%0d pt=%h expected %0d %h", lat, pt, HIT_LAT, PT); end
    release_out(0);
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_aes_variant(1, K192, CT192, 59);
    test_aes_variant(2, K256, CT256, 67);
    test_back_pressure();
    test_back_to_back();
    test_reset_mid();
    test_key_cache();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
